axi_lite_regfile: RTL

AXI4-Lite slave register file that terminates the `axi_if` bus. It consumes the AW/W/B/AR/R channels and maps word-aligned addresses onto NUM_REGS 32-bit read/write registers. The register contents and per-register write pulses are exported to downstream control logic. It supports one outstanding write and one outstanding read, with the two paths operating independently.

---
 rtl/axi_lite_regfile.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite slave register file: NUM_REGS x 32-bit registers at byte address 4*i.
// Latency: a write commits one edge after both AW and W are held; a read returns data one edge after AR.
// Backpressure: one write and one read outstanding; AW/W/AR stall while their buffer or response is held.
// Ports: clk/resetn; AXI4-Lite AW, W, B, AR and R channels (axi_*);
//        reg_out exports all registers (reg i at [32i+31:32i]); wr_pulse flags the register written.
module axi_lite_regfile #(
  parameter int          ADDR_WIDTH = 32,
  parameter int          WIDTH      = 32,
  parameter int          NUM_REGS   = 8,
  parameter logic [31:0] RESET_VAL  = 32'h0
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [ADDR_WIDTH-1:0]     axi_awaddr,
  input  logic [2:0]                axi_awprot,
  input  logic                      axi_awvalid,
  output logic                      axi_awready,
  input  logic [WIDTH-1:0]          axi_wdata,
  input  logic [3:0]                axi_wstrb,
  input  logic                      axi_wvalid,
  output logic                      axi_wready,
  output logic [1:0]                axi_bresp,
  output logic                      axi_bvalid,
  input  logic                      axi_bready,
  input  logic [ADDR_WIDTH-1:0]     axi_araddr,
  input  logic [2:0]                axi_arprot,
  input  logic                      axi_arvalid,
  output logic                      axi_arready,
  output logic [WIDTH-1:0]          axi_rdata,
  output logic [1:0]                axi_rresp,
  output logic                      axi_rvalid,
  input  logic                      axi_rready,
  output logic [NUM_REGS*WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]       wr_pulse
);

  localparam int         IDXW        = ADDR_WIDTH - 2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [WIDTH-1:0] regs [NUM_REGS];

  // Write-side holding buffers
  logic             aw_full;
  logic [IDXW-1:0]  aw_idx;
  logic             w_full;
  logic [WIDTH-1:0] wdata_q;
  logic [3:0]       wstrb_q;

  logic             aw_hs;
  logic             w_hs;
  logic             ar_hs;
  logic             commit;
  logic             aw_hit;
  logic             ar_hit;
  logic [IDXW-1:0]  ar_idx;
  logic [WIDTH-1:0] rd_val;

  // Protection bits and the byte offset within a word carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{axi_awprot, axi_arprot, axi_awaddr[1:0], axi_araddr[1:0]};

  assign axi_awready = ~aw_full;
  assign axi_wready  = ~w_full;
  assign axi_arready = ~axi_rvalid;

  assign aw_hs  = axi_awvalid & ~aw_full;
  assign w_hs   = axi_wvalid & ~w_full;
  assign ar_hs  = axi_arvalid & ~axi_rvalid;
  // A new commit must wait until the previous B response has been taken.
  assign commit = aw_full & w_full & ~axi_bvalid;

  assign ar_idx = axi_araddr[ADDR_WIDTH-1:2];
  assign aw_hit = aw_idx < IDXW'(NUM_REGS);
  assign ar_hit = ar_idx < IDXW'(NUM_REGS);

  // Read mux; a miss matches no register and so returns zero.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_idx == IDXW'(i)) rd_val = regs[i];
    end
  end

  // Write path: buffers, B response and write pulses
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_full    <= 1'b0;
      aw_idx     <= '0;
      w_full     <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      axi_bvalid <= 1'b0;
      axi_bresp  <= RESP_OKAY;
      wr_pulse   <= '0;
    end else begin
      wr_pulse <= '0;
      if (aw_hs) begin
        aw_full <= 1'b1;
        aw_idx  <= axi_awaddr[ADDR_WIDTH-1:2];
      end
      if (w_hs) begin
        w_full  <= 1'b1;
        wdata_q <= axi_wdata;
        wstrb_q <= axi_wstrb;
      end
      // commit implies both buffers full, so it never coincides with a refill.
      if (commit) begin
        aw_full    <= 1'b0;
        w_full     <= 1'b0;
        axi_bvalid <= 1'b1;
        axi_bresp  <= aw_hit ? RESP_OKAY : RESP_SLVERR;
        for (int i = 0; i < NUM_REGS; i++) begin
          if (aw_idx == IDXW'(i)) wr_pulse[i] <= 1'b1;
        end
      end else if (axi_bvalid && axi_bready) begin
        axi_bvalid <= 1'b0;
      end
    end
  end

  // Register storage with byte-lane enables
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
    end else if (commit) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (aw_idx == IDXW'(i)) begin
          for (int b = 0; b < 4; b++) begin
            if (wstrb_q[b]) regs[i][8*b +: 8] <= wdata_q[8*b +: 8];
          end
        end
      end
    end
  end

  // Read path: rd_val is sampled before any same-edge commit lands.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      axi_rvalid <= 1'b0;
      axi_rdata  <= '0;
      axi_rresp  <= RESP_OKAY;
    end else if (ar_hs) begin
      axi_rvalid <= 1'b1;
      axi_rdata  <= rd_val;
      axi_rresp  <= ar_hit ? RESP_OKAY : RESP_SLVERR;
    end else if (axi_rvalid && axi_rready) begin
      axi_rvalid <= 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign reg_out[WIDTH*g +: WIDTH] = regs[g];
  end

endmodule
